// File: rtl/p_reg_6502_if.sv
// ALU/control-to-status-register flag interface: flag ops, ALU flags and data bus in,
// packed P and individual flags back out.
interface p_reg_6502_if;
  logic [3:0] flag_op;
  logic       sync;
  logic       CO;
  logic       V;
  logic       Z;
  logic       N;
  logic [7:0] DI;
  logic       brk_push;
  logic       C_flag;
  logic       Z_flag;
  logic       I_flag;
  logic       D_flag;
  logic       V_flag;
  logic       N_flag;
  logic [7:0] P_out;
  logic       irq_mask;

  modport master (
    output flag_op, sync, CO, V, Z, N, DI, brk_push,
    input  C_flag, Z_flag, I_flag, D_flag, V_flag, N_flag, P_out, irq_mask
  );

  modport slave (
    input  flag_op, sync, CO, V, Z, N, DI, brk_push,
    output C_flag, Z_flag, I_flag, D_flag, V_flag, N_flag, P_out, irq_mask
  );
endinterface

// File: rtl/p_reg_6502.sv
// 6502 processor status register: applies decoded flag ops from the ALU and data bus,
// and keeps an IRQ mask that trails the I flag by one instruction boundary.
module p_reg_6502 #(
  parameter bit RESET_D = 1'b0,
  parameter bit PUSH_B5 = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          RDY,
  p_reg_6502_if.slave   bus
);

  typedef enum logic [3:0] {
    OpNone   = 4'b0000,
    OpNz     = 4'b0001,
    OpNzc    = 4'b0010,
    OpNzcv   = 4'b0011,
    OpBit    = 4'b0100,
    OpPlp    = 4'b0101,
    OpClc    = 4'b0110,
    OpSec    = 4'b0111,
    OpCli    = 4'b1000,
    OpSei    = 4'b1001,
    OpCld    = 4'b1010,
    OpSed    = 4'b1011,
    OpClv    = 4'b1100,
    OpIntEnt = 4'b1101,
    OpLoad   = 4'b1110,
    OpRsvd   = 4'b1111
  } flag_op_e;

  logic c_q, z_q, i_q, d_q, v_q, n_q, mask_q;
  logic c_d, z_d, i_d, d_d, v_d, n_d, mask_d;

  always_comb begin
    c_d    = c_q;
    z_d    = z_q;
    i_d    = i_q;
    d_d    = d_q;
    v_d    = v_q;
    n_d    = n_q;
    mask_d = mask_q;
    if (RDY) begin
      unique case (flag_op_e'(bus.flag_op))
        OpNz:   begin n_d = bus.N; z_d = bus.Z; end
        OpNzc:  begin n_d = bus.N; z_d = bus.Z; c_d = bus.CO; end
        OpNzcv: begin n_d = bus.N; z_d = bus.Z; c_d = bus.CO; v_d = bus.V; end
        OpBit:  begin n_d = bus.DI[7]; v_d = bus.DI[6]; z_d = bus.Z; end
        OpPlp: begin
          // DI[5:4] are not real flags and are dropped.
          n_d = bus.DI[7];
          v_d = bus.DI[6];
          d_d = bus.DI[3];
          i_d = bus.DI[2];
          z_d = bus.DI[1];
          c_d = bus.DI[0];
        end
        OpClc:    c_d = 1'b0;
        OpSec:    c_d = 1'b1;
        OpCli:    i_d = 1'b0;
        OpSei:    i_d = 1'b1;
        OpCld:    d_d = 1'b0;
        OpSed:    d_d = 1'b1;
        OpClv:    v_d = 1'b0;
        OpIntEnt: i_d = 1'b1;
        OpLoad:   begin n_d = bus.DI[7]; z_d = (bus.DI == 8'h00); end
        OpNone, OpRsvd: ;
        default: ;
      endcase
      // Mask samples the pre-update I so CLI/SEI/PLP act one instruction late.
      if (bus.flag_op == OpIntEnt) begin
        mask_d = 1'b1;
      end else if (bus.sync) begin
        mask_d = i_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      c_q    <= 1'b0;
      z_q    <= 1'b0;
      i_q    <= 1'b1;
      d_q    <= RESET_D;
      v_q    <= 1'b0;
      n_q    <= 1'b0;
      mask_q <= 1'b1;
    end else begin
      c_q    <= c_d;
      z_q    <= z_d;
      i_q    <= i_d;
      d_q    <= d_d;
      v_q    <= v_d;
      n_q    <= n_d;
      mask_q <= mask_d;
    end
  end

  assign bus.C_flag   = c_q;
  assign bus.Z_flag   = z_q;
  assign bus.I_flag   = i_q;
  assign bus.D_flag   = d_q;
  assign bus.V_flag   = v_q;
  assign bus.N_flag   = n_q;
  assign bus.irq_mask = mask_q;
  assign bus.P_out    = {n_q, v_q, PUSH_B5, bus.brk_push, d_q, i_q, z_q, c_q};

endmodule

// File: tb/tb_p_reg_6502.sv
// Directed vector bench for p_reg_6502; expected flags are hand-computed per row.
module tb_p_reg_6502;

  logic clk = 1'b0;
  logic reset_n;
  logic RDY;
  int   checks = 0;
  int   failures = 0;

  p_reg_6502_if bus ();

  p_reg_6502 #(.RESET_D(1'b0), .PUSH_B5(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .RDY     (RDY),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // exp_f is {N,V,D,I,Z,C}
  typedef struct {
    logic [3:0] op;
    logic [7:0] di;
    logic       co, v, z, n;
    logic       sync, rdy, brk;
    logic [5:0] exp_f;
    logic       exp_m;
  } vec_t;

  vec_t vecs[25];

  function automatic logic [5:0] flags();
    return {bus.N_flag, bus.V_flag, bus.D_flag, bus.I_flag, bus.Z_flag, bus.C_flag};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    @(negedge clk);
    bus.flag_op  = t.op;
    bus.DI       = t.di;
    bus.CO       = t.co;
    bus.V        = t.v;
    bus.Z        = t.z;
    bus.N        = t.n;
    bus.sync     = t.sync;
    bus.brk_push = t.brk;
    RDY          = t.rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           op       di     co v  z  n  sy rdy brk  exp_f      m
    vecs[0]  = '{4'b0011, 8'h00, 1, 1, 0, 1, 0, 1, 1, 6'b110101, 1};
    vecs[1]  = '{4'b0110, 8'h00, 0, 0, 1, 0, 1, 0, 0, 6'b110101, 1};
    vecs[2]  = '{4'b0101, 8'hFF, 0, 0, 0, 0, 0, 1, 0, 6'b111111, 1};
    vecs[3]  = '{4'b0101, 8'h30, 1, 1, 1, 1, 0, 1, 1, 6'b000000, 1};
    vecs[4]  = '{4'b0111, 8'h00, 0, 0, 0, 0, 0, 1, 0, 6'b000001, 1};
    vecs[5]  = '{4'b0100, 8'hC0, 0, 0, 1, 0, 0, 1, 1, 6'b110011, 1};
    vecs[6]  = '{4'b0110, 8'h00, 0, 0, 0, 0, 0, 1, 0, 6'b110010, 1};
    vecs[7]  = '{4'b1011, 8'h00, 0, 0, 0, 0, 0, 1, 1, 6'b111010, 1};
    vecs[8]  = '{4'b1010, 8'h00, 0, 0, 0, 0, 0, 1, 0, 6'b110010, 1};
    vecs[9]  = '{4'b1100, 8'h00, 0, 0, 0, 0, 0, 1, 1, 6'b100010, 1};
    vecs[10] = '{4'b1110, 8'h00, 0, 0, 0, 1, 0, 1, 0, 6'b000010, 1};
    vecs[11] = '{4'b1110, 8'h80, 0, 0, 1, 0, 0, 1, 1, 6'b100000, 1};
    vecs[12] = '{4'b0001, 8'h00, 1, 1, 1, 0, 0, 1, 0, 6'b000010, 1};
    vecs[13] = '{4'b0010, 8'h00, 1, 1, 0, 1, 0, 1, 1, 6'b100001, 1};
    vecs[14] = '{4'b1111, 8'hFF, 0, 1, 1, 0, 0, 1, 0, 6'b100001, 1};
    vecs[15] = '{4'b0000, 8'h00, 0, 1, 1, 0, 0, 1, 1, 6'b100001, 1};
    vecs[16] = '{4'b0000, 8'h00, 0, 0, 0, 0, 1, 1, 0, 6'b100001, 0};
    vecs[17] = '{4'b1001, 8'h00, 0, 0, 0, 0, 0, 1, 1, 6'b100101, 0};
    vecs[18] = '{4'b1000, 8'h00, 0, 0, 0, 0, 1, 1, 0, 6'b100001, 1};
    vecs[19] = '{4'b0000, 8'h00, 0, 0, 0, 0, 1, 1, 1, 6'b100001, 0};
    vecs[20] = '{4'b1011, 8'h00, 0, 0, 0, 0, 0, 1, 0, 6'b101001, 0};
    vecs[21] = '{4'b1101, 8'h00, 0, 0, 0, 0, 1, 1, 1, 6'b101101, 1};
    vecs[22] = '{4'b1000, 8'h00, 0, 0, 0, 0, 0, 1, 0, 6'b101001, 1};
    vecs[23] = '{4'b0000, 8'h00, 0, 0, 0, 0, 1, 1, 1, 6'b101001, 0};
    vecs[24] = '{4'b1101, 8'h00, 0, 0, 0, 0, 1, 0, 0, 6'b101001, 0};

    reset_n      = 1'b0;
    RDY          = 1'b0;
    bus.flag_op  = 4'b0000;
    bus.DI       = 8'h00;
    bus.CO       = 1'b0;
    bus.V        = 1'b0;
    bus.Z        = 1'b0;
    bus.N        = 1'b0;
    bus.sync     = 1'b0;
    bus.brk_push = 1'b1;

    // Reset with RDY low
    @(posedge clk);
    #1;
    check("reset_flags", {2'b00, flags()}, 8'h04);
    check("reset_mask", {7'd0, bus.irq_mask}, 8'h01);
    check("reset_p_brk1", bus.P_out, 8'h34);
    bus.brk_push = 1'b0;
    #1;
    check("reset_p_brk0", bus.P_out, 8'h24);

    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i]);
      check($sformatf("vec%0d_flags", i), {2'b00, flags()}, {2'b00, vecs[i].exp_f});
      check($sformatf("vec%0d_mask", i), {7'd0, bus.irq_mask}, {7'd0, vecs[i].exp_m});
      check($sformatf("vec%0d_p", i), bus.P_out,
            {vecs[i].exp_f[5:4], 1'b1, vecs[i].brk, vecs[i].exp_f[3:0]});
    end

    // PLP of FF with an IRQ-style push: all flags set, B clear
    drive('{4'b0101, 8'hFF, 0, 0, 0, 0, 0, 1, 0, 6'b111111, 1});
    check("plp_ff_p", bus.P_out, 8'hEF);

    // Reset mid-sequence while a PLP and sync are also presented
    @(negedge clk);
    reset_n     = 1'b0;
    RDY         = 1'b1;
    bus.flag_op = 4'b0101;
    bus.DI      = 8'hFF;
    bus.sync    = 1'b1;
    bus.brk_push = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_flags", {2'b00, flags()}, 8'h04);
    check("midreset_mask", {7'd0, bus.irq_mask}, 8'h01);
    check("midreset_p", bus.P_out, 8'h34);

    // Hold in reset for a cycle, then release and confirm advance resumes
    @(negedge clk);
    reset_n = 1'b1;
    bus.flag_op = 4'b0111;
    bus.sync = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_sec", {2'b00, flags()}, 8'h05);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/p_reg_6502.md
Name: p_reg_6502

Overview:
- Processor status register (P) for the 6502 core. It is the consumer end of the ALU flag interface.
- Captures the ALU's registered CO/V/Z/N outputs under decoded flag operations, and loads or sets flags from the data bus and from control ops.
- Feeds carry-in and decimal mode back to the ALU and produces the packed P byte for PHP/BRK/IRQ pushes.
- Provides an interrupt mask that follows the I flag one instruction late, matching NMOS 6502 timing.

Parameters:
- RESET_D, 0, value loaded into D on reset (0 = binary mode).
- PUSH_B5, 1, value driven on bit 5 of the pushed P byte.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  synchronous active-low reset.
- RDY  in  1  global advance enable; when 0 all state holds.
- flag_op  in  4  flag operation applied at next edge (encoding below).
- sync  in  1  instruction-boundary strobe (opcode fetch cycle).
- CO  in  1  ALU carry out (registered in ALU).
- V  in  1  ALU overflow.
- Z  in  1  ALU zero.
- N  in  1  ALU negative.
- DI  in  8  data bus in (PLP/RTI byte, BIT operand, load value).
- brk_push  in  1  1 = push is from BRK/PHP (B=1); 0 = hardware IRQ/NMI (B=0).
- C_flag  out  1  carry; drives ALU CI.
- Z_flag  out  1  zero.
- I_flag  out  1  interrupt disable.
- D_flag  out  1  decimal; drives ALU BCD.
- V_flag  out  1  overflow.
- N_flag  out  1  negative.
- P_out  out  8  push byte {N,V,PUSH_B5,brk_push,D,I,Z,C}, combinational.
- irq_mask  out  1  effective IRQ inhibit used by interrupt logic.

Behaviour:
- Reset: sampled on a clk edge with reset_n=0, regardless of RDY.
  - Reset values: C=Z=V=N=0, D=RESET_D, I=1, irq_mask=1.
- Advance: update only at an edge with reset_n=1 and RDY=1. RDY=0 holds all flags and irq_mask; flag_op and sync are ignored.
- Latency: a flag_op presented in cycle t is visible on the flag outputs in cycle t+1. It is issued in the cycle where the ALU's registered outputs are valid.
- flag_op encoding (flags not listed hold):
  - 0000 none
  - 0001 N<=N, Z<=Z
  - 0010 N, Z, C<=CO
  - 0011 N, Z, C<=CO, V<=V
  - 0100 BIT: N<=DI[7], V<=DI[6], Z<=Z
  - 0101 PLP/RTI: {N,V,D,I,Z,C}<=DI[7,6,3,2,1,0]; DI[5:4] discarded
  - 0110 C<=0
  - 0111 C<=1
  - 1000 I<=0
  - 1001 I<=1
  - 1010 D<=0
  - 1011 D<=1
  - 1100 V<=0
  - 1101 interrupt entry: I<=1, irq_mask<=1 same edge; D unchanged (NMOS)
  - 1110 load: N<=DI[7], Z<=(DI==0)
  - 1111 reserved, treated as none
- irq_mask rules:
  - On an advancing edge with sync=1: irq_mask <= I value before this edge's flag_op.
  - As a result, CLI/SEI/PLP take effect on masking only after the following instruction's sync.
  - flag_op=1101 sets irq_mask=1 immediately; it overrides sync on the same edge.
  - Otherwise irq_mask holds.
- Simultaneous events:
  - sync with any flag_op: the flag update and irq_mask sampling both occur; irq_mask sees the old I.
  - reset_n=0 overrides everything.
- Outputs: P_out is combinational from current flags and brk_push. No X on any output after reset.

Test Plan:
- Reset with RDY=0 -> I=1, irq_mask=1, C=Z=V=N=D=0, P_out=8'h34 when brk_push=1, 8'h24 when brk_push=0.
- CO=1, V=1, N=1, Z=0, flag_op=0011, RDY=1 -> next cycle C=1, V=1, N=1, Z=0; same inputs with RDY=0 -> no change.
- flag_op=0101, DI=8'hFF -> N,V,D,I,Z,C all 1, P_out=8'hEF with brk_push=0; then DI=8'h30 -> all flags 0.
- BIT: DI=8'hC0, Z=1, flag_op=0100 -> N=1, V=1, Z=1, C unchanged.
- I=1, flag_op=1000 with sync=0 -> I=0 next cycle, irq_mask stays 1; next sync pulse -> irq_mask=0. Issuing 1000 together with sync -> irq_mask still 1 for that sync.
- irq_mask=0, flag_op=1101 with sync=1 -> I=1 and irq_mask=1 on the same edge; then reset_n=0 mid-sequence -> all flags return to reset values.
